// File: rtl/hc595_serial_tx_if.sv
// Handshake bundle between the word producer and the 74HC595 transmitter.
// Latency: none (wires only).
// Backpressure: producer holds valid/data until it sees ready; busy mirrors ~ready.
// Ports: data (parallel word), valid (word offered), ready (idle, can accept),
//        busy (transfer in progress).
interface hc595_serial_tx_if #(
   parameter int data_width = 16
) ();
   logic [data_width-1:0] data;
   logic                  valid;
   logic                  ready;
   logic                  busy;

   modport master (output data, output valid, input ready, input busy);
   modport slave  (input data, input valid, output ready, output busy);
endinterface

// File: rtl/hc595_serial_tx.sv
// Serial transmitter for a 74HC595 chain: shifts a word out on sdata/sclk, then pulses rclk.
// Latency: ready returns (2*data_width+1) * 2**shift_strobe_width cycles after acceptance.
// Backpressure: ready is low for the whole transfer; valid while busy is ignored.
// Ports: clk, reset (async, active-low), host (slave handshake: data/valid/ready/busy),
//        sdata -> SER, sclk -> SRCLK, rclk -> RCLK. All outputs are registered.
// Option: define HC595_SERIAL_TX_LSB_FIRST_EN to transmit LSB first (default MSB first).
module hc595_serial_tx #(
   parameter int data_width         = 16,
   parameter int shift_strobe_width = 10
) (
   input  logic                clk,
   input  logic                reset,
   hc595_serial_tx_if.slave    host,
   output logic                sdata,
   output logic                sclk,
   output logic                rclk
);

   localparam int bcw = $clog2(data_width);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SHIFT_LOW  = 2'd1,
      SHIFT_HIGH = 2'd2,
      LATCH      = 2'd3
   } state_t;

   state_t                        state_q, state_d;
   logic [shift_strobe_width-1:0] strobe_q, strobe_d;
   logic [bcw-1:0]                bit_q, bit_d;
   logic [data_width-1:0]         shreg_q, shreg_d;
   logic                          sdata_d, sclk_d, rclk_d;
   logic                          ready_q, ready_d;
   logic                          tick;
   logic                          accept;

   // One tick per strobe period; the counter wraps naturally after all ones.
   assign tick   = &strobe_q;
   assign accept = host.valid && ready_q;

   always_comb begin
      state_d  = state_q;
      strobe_d = (state_q == IDLE) ? strobe_q : strobe_q + 1'b1;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      sdata_d  = sdata;
      sclk_d   = sclk;
      rclk_d   = rclk;
      ready_d  = ready_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d  = host.data;
`ifdef HC595_SERIAL_TX_LSB_FIRST_EN
               sdata_d  = host.data[0];
`else
               sdata_d  = host.data[data_width-1];
`endif
               sclk_d   = 1'b0;
               bit_d    = '0;
               strobe_d = '0;
               ready_d  = 1'b0;
               state_d  = SHIFT_LOW;
            end
         end
         SHIFT_LOW: begin
            if (tick) begin
               sclk_d  = 1'b1;
               state_d = SHIFT_HIGH;
            end
         end
         SHIFT_HIGH: begin
            if (tick) begin
               sclk_d = 1'b0;
               if (bit_q == bcw'(data_width - 1)) begin
                  rclk_d  = 1'b1;
                  state_d = LATCH;
               end else begin
                  // Rotate rather than zero-fill: the wrapped bit is never
                  // transmitted, and every register bit stays in use.
`ifdef HC595_SERIAL_TX_LSB_FIRST_EN
                  shreg_d = {shreg_q[0], shreg_q[data_width-1:1]};
                  sdata_d = shreg_q[1];
`else
                  shreg_d = {shreg_q[data_width-2:0], shreg_q[data_width-1]};
                  sdata_d = shreg_q[data_width-2];
`endif
                  bit_d   = bit_q + 1'b1;
                  state_d = SHIFT_LOW;
               end
            end
         end
         LATCH: begin
            if (tick) begin
               rclk_d  = 1'b0;
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            sclk_d  = 1'b0;
            rclk_d  = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         strobe_q <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         sdata    <= 1'b0;
         sclk     <= 1'b0;
         rclk     <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         strobe_q <= strobe_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         sdata    <= sdata_d;
         sclk     <= sclk_d;
         rclk     <= rclk_d;
         ready_q  <= ready_d;
      end
   end

   assign host.ready = ready_q;
   assign host.busy  = ~ready_q;

endmodule
